// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and stall/flush controls for pipe_hazard_ctrl
// Optional perf counter signals exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  logic [4:0] idRsAddr;
  logic [4:0] idRtAddr;
  logic       idUsesRs;
  logic       idUsesRt;
  logic       exMemRead;
  logic [4:0] exWriteRegAddr;
  logic       branchTakenE;
  logic       memReqM;
  logic       memAckM;
  logic       pcEn;
  logic       ifidEn;
  logic       ifidFlush;
  logic       idexEn;
  logic       idexFlush;
  logic       exmemEn;
  logic       memwbBubble;
  logic       memErr;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stallCycles;
  logic [31:0] flushCount;
  logic [15:0] timeoutCount;
`endif

  modport master (
    output idRsAddr, idRtAddr, idUsesRs, idUsesRt, exMemRead, exWriteRegAddr,
           branchTakenE, memReqM, memAckM,
    input  pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbBubble, memErr
`ifdef PIPE_HAZARD_PERF_EN
    , input stallCycles, flushCount, timeoutCount
`endif
  );

  modport slave (
    input  idRsAddr, idRtAddr, idUsesRs, idUsesRt, exMemRead, exWriteRegAddr,
           branchTakenE, memReqM, memAckM,
    output pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbBubble, memErr
`ifdef PIPE_HAZARD_PERF_EN
    , output stallCycles, flushCount, timeoutCount
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// PIPE_HAZARD_PERF_EN adds stall, flush and timeout counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {S_RUN, S_MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_mem_err;
  logic             w_timeout;
  logic             w_freeze;
  logic             w_load_use;
  logic             w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
  logic             w_exmem_en, w_memwb_bubble;

  assign w_load_use = bus.exMemRead && (bus.exWriteRegAddr != 5'd0) &&
                      ((bus.idUsesRs && (bus.idRsAddr == bus.exWriteRegAddr)) ||
                       (bus.idUsesRt && (bus.idRtAddr == bus.exWriteRegAddr)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mem_err <= w_timeout;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_timeout      = 1'b0;
    w_freeze       = 1'b0;
    w_pc_en        = 1'b1;
    w_ifid_en      = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_en      = 1'b1;
    w_idex_flush   = 1'b0;
    w_exmem_en     = 1'b1;
    w_memwb_bubble = 1'b0;

    if (r_state == S_RUN) begin
      if (bus.memReqM && !bus.memAckM) begin
        w_freeze    = 1'b1;
        w_state_nxt = S_MEM_WAIT;
        w_cnt_nxt   = CNT_W'(1);
      end
    end else begin
      if (bus.memAckM) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end else if (r_cnt == LP_LAST) begin
        // Give up on the hung access: release, but drop the faulting write.
        w_timeout   = 1'b1;
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_freeze  = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    if (!rst) begin
      w_state_nxt    = S_RUN;
      w_cnt_nxt      = '0;
      w_pc_en        = 1'b0;
      w_ifid_en      = 1'b0;
      w_idex_en      = 1'b0;
      w_exmem_en     = 1'b0;
    end else if (w_freeze) begin
      w_pc_en        = 1'b0;
      w_ifid_en      = 1'b0;
      w_idex_en      = 1'b0;
      w_exmem_en     = 1'b0;
      w_memwb_bubble = 1'b1;
    end else begin
      w_memwb_bubble = w_timeout;
      if (bus.branchTakenE) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_flush = 1'b1;
      end
    end
  end

  assign bus.pcEn        = w_pc_en;
  assign bus.ifidEn      = w_ifid_en;
  assign bus.ifidFlush   = w_ifid_flush;
  assign bus.idexEn      = w_idex_en;
  assign bus.idexFlush   = w_idex_flush;
  assign bus.exmemEn     = w_exmem_en;
  assign bus.memwbBubble = w_memwb_bubble;
  assign bus.memErr      = r_mem_err;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;
  logic [15:0] r_timeout_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_timeout_count <= '0;
    end else begin
      if (!w_pc_en)     r_stall_cycles  <= r_stall_cycles + 32'd1;
      if (w_ifid_flush) r_flush_count   <= r_flush_count + 32'd1;
      if (r_mem_err)    r_timeout_count <= r_timeout_count + 16'd1;
    end
  end

  assign bus.stallCycles  = r_stall_cycles;
  assign bus.flushCount   = r_flush_count;
  assign bus.timeoutCount = r_timeout_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: is a memory access outstanding, how long has it waited, error pending
  bit   m_wait;
  int   m_cnt;
  bit   m_err;
  logic [7:0] last_out;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mr;
    logic [4:0] exw;
    logic       br, req, ack;
    logic [6:0] exp;
  } vec_t;
  vec_t vt[10];

  function automatic logic [7:0] dut_out();
    return {bus.pcEn, bus.ifidEn, bus.ifidFlush, bus.idexEn, bus.idexFlush,
            bus.exmemEn, bus.memwbBubble, bus.memErr};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic bit gives_up();
    return m_wait && !bus.memAckM && (m_cnt == T - 1);
  endfunction

  function automatic bit frozen();
    return (!m_wait && bus.memReqM && !bus.memAckM) ||
           (m_wait && !bus.memAckM && (m_cnt != T - 1));
  endfunction

  function automatic logic [7:0] model_out();
    logic [6:0] c;
    bit lu;
    lu = bus.exMemRead && bus.exWriteRegAddr != 0 &&
         ((bus.idUsesRs && bus.idRsAddr == bus.exWriteRegAddr) ||
          (bus.idUsesRt && bus.idRtAddr == bus.exWriteRegAddr));
    if (!rst)              c = 7'b0000000;
    else if (frozen())     c = 7'b0000001;
    else if (bus.branchTakenE) c = {6'b111111, gives_up()};
    else if (lu)           c = {6'b000111, gives_up()};
    else                   c = {6'b110101, gives_up()};
    return {c, m_err};
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_wait = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_err = gives_up();
      if (frozen()) begin
        m_cnt  = m_wait ? m_cnt + 1 : 1;
        m_wait = 1;
      end else begin
        m_wait = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic tick(input string name);
    @(negedge clk);
    last_out = dut_out();
    chk(name, last_out, model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mr, input logic [4:0] exw,
                        input logic br, input logic req, input logic ack);
    bus.idRsAddr = rs; bus.idRtAddr = rt; bus.idUsesRs = urs; bus.idUsesRt = urt;
    bus.exMemRead = mr; bus.exWriteRegAddr = exw; bus.branchTakenE = br;
    bus.memReqM = req; bus.memAckM = ack;
  endtask

  task automatic run_timeout(input string name);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < T - 1; c++) begin
      tick(name);
      chk({name, "_stall"}, {last_out[7:1], 1'b0}, 8'b00000010);
    end
    tick(name);
    chk({name, "_release"}, last_out, 8'b11010110);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(name);
    chk({name, "_err"}, last_out, 8'b11010101);
    tick(name);
    chk({name, "_err_once"}, last_out, 8'b11010100);
  endtask

  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1101010};
    vt[1] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1101010};
    vt[2] = '{0, 5, 0, 1, 1, 5, 0, 0, 0, 7'b0001110};
    vt[3] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 7'b1101010};
    vt[4] = '{9, 2, 1, 0, 1, 9, 0, 0, 0, 7'b0001110};
    vt[5] = '{9, 2, 0, 1, 1, 9, 0, 0, 0, 7'b1101010};
    vt[6] = '{7, 7, 1, 1, 0, 7, 0, 0, 0, 7'b1101010};
    vt[7] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111110};
    vt[8] = '{3, 5, 0, 1, 1, 5, 1, 0, 0, 7'b1111110};
    vt[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b1111110};

    m_wait = 0; m_cnt = 0; m_err = 0;
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    tick("reset");
    chk("reset_outputs", last_out, 8'b00000000);
    rst = 1;

    foreach (vt[i]) begin
      set_in(vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt, vt[i].mr, vt[i].exw,
             vt[i].br, vt[i].req, vt[i].ack);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_exp", i), {last_out[7:1], 1'b0}, {vt[i].exp, 1'b0});
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 10; c++) begin
      tick("zero_wait");
      chk("zero_wait_run", last_out, 8'b11010100);
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      tick("mem3");
      chk("mem3_stall", last_out, 8'b00000010);
    end
    bus.memAckM = 1;
    tick("mem3");
    chk("mem3_ack", last_out, 8'b11010100);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("mem3");
    chk("mem3_no_err", last_out, 8'b11010100);

    run_timeout("timeout");

    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 2; c++) begin
      tick("br_wait");
      chk("br_wait_noflush", last_out, 8'b00000010);
    end
    bus.memAckM = 1;
    tick("br_ack");
    chk("br_ack_flush", last_out, 8'b11111100);

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 7; c++) tick("pre_reset_wait");
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      tick("mid_reset");
      chk("mid_reset_zero", last_out, 8'b00000000);
    end
    rst = 1;
    run_timeout("post_reset");

    for (int i = 0; i < 600; i++) begin
      bit slow;
      slow = ((i / 100) % 2) == 1;
      rst = ($urandom_range(0, 59) != 0);
      bus.idRsAddr = 5'($urandom_range(0, 3));
      bus.idRtAddr = 5'($urandom_range(0, 3));
      bus.idUsesRs = 1'($urandom_range(0, 1));
      bus.idUsesRt = 1'($urandom_range(0, 1));
      bus.exMemRead = 1'($urandom_range(0, 1));
      bus.exWriteRegAddr = 5'($urandom_range(0, 3));
      bus.branchTakenE = ($urandom_range(0, 4) == 0);
      bus.memReqM = 1'($urandom_range(0, 1));
      bus.memAckM = slow ? ($urandom_range(0, 24) == 0) : 1'($urandom_range(0, 1));
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
